// File: rtl/id_exe_reg.sv
// ID/EXE pipeline register for the 32-bit ARM core.
// Captures the decoded instruction from ID and presents it to EXE one cycle later.
// Supports freeze (hold) and flush (bubble). Non-valid ID slots are loaded as bubbles.
module id_exe_reg #(
    parameter int DW = 32,
    parameter int RW = 4,
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          freeze,
    input  logic          flush,
    input  logic          id_valid,
    input  logic [DW-1:0] id_pc,
    input  logic [DW-1:0] id_rn_val,
    input  logic [DW-1:0] id_rm_val,
    input  logic [11:0]   id_shift_op,
    input  logic          id_imm,
    input  logic [23:0]   id_imm24,
    input  logic [CW-1:0] id_exe_cmd,
    input  logic          id_mem_r_en,
    input  logic          id_mem_w_en,
    input  logic          id_wb_en,
    input  logic          id_s,
    input  logic          id_b,
    input  logic [RW-1:0] id_dest,
    input  logic [RW-1:0] id_src1,
    input  logic [RW-1:0] id_src2,
    input  logic          id_status_c,
    output logic          exe_valid,
    output logic [DW-1:0] exe_pc,
    output logic [DW-1:0] exe_rn_val,
    output logic [DW-1:0] exe_rm_val,
    output logic [11:0]   exe_shift_op,
    output logic          exe_imm,
    output logic [23:0]   exe_imm24,
    output logic [CW-1:0] exe_exe_cmd,
    output logic          exe_mem_r_en,
    output logic          exe_mem_w_en,
    output logic          exe_wb_en,
    output logic          exe_s,
    output logic          exe_b,
    output logic [RW-1:0] exe_dest,
    output logic [RW-1:0] exe_src1,
    output logic [RW-1:0] exe_src2,
    output logic          exe_status_c
);

    typedef struct packed {
        logic          valid;
        logic [DW-1:0] pc;
        logic [DW-1:0] rn_val;
        logic [DW-1:0] rm_val;
        logic [11:0]   shift_op;
        logic          imm;
        logic [23:0]   imm24;
        logic [CW-1:0] exe_cmd;
        logic          mem_r_en;
        logic          mem_w_en;
        logic          wb_en;
        logic          s;
        logic          b;
        logic [RW-1:0] dest;
        logic [RW-1:0] src1;
        logic [RW-1:0] src2;
        logic          status_c;
    } slot_t;

    slot_t id_slot;
    slot_t slot_d;
    slot_t slot_q;

    assign id_slot = '{
        valid:    id_valid,
        pc:       id_pc,
        rn_val:   id_rn_val,
        rm_val:   id_rm_val,
        shift_op: id_shift_op,
        imm:      id_imm,
        imm24:    id_imm24,
        exe_cmd:  id_exe_cmd,
        mem_r_en: id_mem_r_en,
        mem_w_en: id_mem_w_en,
        wb_en:    id_wb_en,
        s:        id_s,
        b:        id_b,
        dest:     id_dest,
        src1:     id_src1,
        src2:     id_src2,
        status_c: id_status_c
    };

    // Next slot: freeze holds, flush or an empty ID slot loads an all-zero bubble.
    always_comb begin
        slot_d = slot_q;
        if (!freeze) begin
            if (flush || !id_valid) slot_d = '0;
            else                    slot_d = id_slot;
        end
    end

    // Slot register; reset overrides freeze and flush.
    always_ff @(posedge clk) begin
        if (rst) slot_q <= '0;
        else     slot_q <= slot_d;
    end

    assign exe_valid    = slot_q.valid;
    assign exe_pc       = slot_q.pc;
    assign exe_rn_val   = slot_q.rn_val;
    assign exe_rm_val   = slot_q.rm_val;
    assign exe_shift_op = slot_q.shift_op;
    assign exe_imm      = slot_q.imm;
    assign exe_imm24    = slot_q.imm24;
    assign exe_exe_cmd  = slot_q.exe_cmd;
    assign exe_mem_r_en = slot_q.mem_r_en;
    assign exe_mem_w_en = slot_q.mem_w_en;
    assign exe_wb_en    = slot_q.wb_en;
    assign exe_s        = slot_q.s;
    assign exe_b        = slot_q.b;
    assign exe_dest     = slot_q.dest;
    assign exe_src1     = slot_q.src1;
    assign exe_src2     = slot_q.src2;
    assign exe_status_c = slot_q.status_c;

    // A bubble must never carry a side-effect enable.
    a_bubble_clean: assert property (@(posedge clk)
        !slot_q.valid |-> !(slot_q.mem_r_en || slot_q.mem_w_en || slot_q.wb_en || slot_q.s || slot_q.b));

    // ID never issues a load and a store in one slot; flag it if it does.
    a_rw_exclusive: assert property (@(posedge clk) disable iff (rst)
        !(slot_q.mem_r_en && slot_q.mem_w_en));

endmodule

// File: tb/tb_id_exe_reg.sv
// Directed testbench for id_exe_reg: reset, load, freeze, flush, priority and back-to-back.
module tb_id_exe_reg;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rn_val;
        logic [31:0] rm_val;
        logic [11:0] shift_op;
        logic        imm;
        logic [23:0] imm24;
        logic [3:0]  exe_cmd;
        logic        mem_r_en;
        logic        mem_w_en;
        logic        wb_en;
        logic        s;
        logic        b;
        logic [3:0]  dest;
        logic [3:0]  src1;
        logic [3:0]  src2;
        logic        status_c;
    } instr_t;

    logic clk = 1'b0;
    logic rst, freeze, flush;
    instr_t id;
    instr_t obs;

    logic        exe_valid;
    logic [31:0] exe_pc, exe_rn_val, exe_rm_val;
    logic [11:0] exe_shift_op;
    logic        exe_imm;
    logic [23:0] exe_imm24;
    logic [3:0]  exe_exe_cmd;
    logic        exe_mem_r_en, exe_mem_w_en, exe_wb_en, exe_s, exe_b;
    logic [3:0]  exe_dest, exe_src1, exe_src2;
    logic        exe_status_c;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    id_exe_reg #(.DW(32), .RW(4), .CW(4)) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
        .id_valid(id.valid), .id_pc(id.pc), .id_rn_val(id.rn_val), .id_rm_val(id.rm_val),
        .id_shift_op(id.shift_op), .id_imm(id.imm), .id_imm24(id.imm24), .id_exe_cmd(id.exe_cmd),
        .id_mem_r_en(id.mem_r_en), .id_mem_w_en(id.mem_w_en), .id_wb_en(id.wb_en),
        .id_s(id.s), .id_b(id.b), .id_dest(id.dest), .id_src1(id.src1), .id_src2(id.src2),
        .id_status_c(id.status_c),
        .exe_valid(exe_valid), .exe_pc(exe_pc), .exe_rn_val(exe_rn_val), .exe_rm_val(exe_rm_val),
        .exe_shift_op(exe_shift_op), .exe_imm(exe_imm), .exe_imm24(exe_imm24), .exe_exe_cmd(exe_exe_cmd),
        .exe_mem_r_en(exe_mem_r_en), .exe_mem_w_en(exe_mem_w_en), .exe_wb_en(exe_wb_en),
        .exe_s(exe_s), .exe_b(exe_b), .exe_dest(exe_dest), .exe_src1(exe_src1), .exe_src2(exe_src2),
        .exe_status_c(exe_status_c)
    );

    assign obs = '{exe_valid, exe_pc, exe_rn_val, exe_rm_val, exe_shift_op, exe_imm, exe_imm24,
                   exe_exe_cmd, exe_mem_r_en, exe_mem_w_en, exe_wb_en, exe_s, exe_b,
                   exe_dest, exe_src1, exe_src2, exe_status_c};

    // Random valid instruction; never both load and store.
    function automatic instr_t rand_instr();
        instr_t t;
        t          = instr_t'({$urandom, $urandom, $urandom, $urandom, $urandom});
        t.valid    = 1'b1;
        if (t.mem_r_en) t.mem_w_en = 1'b0;
        return t;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; freeze = 1'b0; flush = 1'b0;
        id = rand_instr();
        tick();
        n_tests++;
        if (obs !== 156'd0) begin
            n_fail++; $display("FAIL reset_all obs=%h exp=0", obs);
        end
        n_tests++;
        if (exe_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid got=%b exp=0", exe_valid);
        end
        rst = 1'b0;
    endtask

    task automatic test_load();
        instr_t a;
        a = '0;
        a.valid = 1'b1; a.pc = 32'h0000_0104; a.rm_val = 32'hDEAD_BEEF; a.dest = 4'd5; a.wb_en = 1'b1;
        id = a;
        tick();
        n_tests++;
        if (obs !== a) begin
            n_fail++; $display("FAIL load_all obs=%h exp=%h", obs, a);
        end
        n_tests++;
        if (exe_valid !== 1'b1 || exe_pc !== 32'h0000_0104 || exe_rm_val !== 32'hDEAD_BEEF ||
            exe_dest !== 4'd5 || exe_wb_en !== 1'b1) begin
            n_fail++; $display("FAIL load_fields valid=%b pc=%h rm=%h dest=%0d wb=%b exp 1/00000104/deadbeef/5/1",
                               exe_valid, exe_pc, exe_rm_val, exe_dest, exe_wb_en);
        end
    endtask

    task automatic test_invalid();
        instr_t t;
        t = rand_instr();
        t.valid = 1'b0;
        id = t;
        tick();
        n_tests++;
        if (obs !== 156'd0) begin
            n_fail++; $display("FAIL invalid_bubble obs=%h exp=0", obs);
        end
    endtask

    task automatic test_freeze();
        instr_t a, b;
        a = rand_instr();
        b = rand_instr();
        id = a;
        tick();
        freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            id = rand_instr();
            tick();
            n_tests++;
            if (obs !== a) begin
                n_fail++; $display("FAIL freeze_hold%0d obs=%h exp=%h", i, obs, a);
            end
        end
        freeze = 1'b0;
        id = b;
        tick();
        n_tests++;
        if (obs !== b) begin
            n_fail++; $display("FAIL freeze_release obs=%h exp=%h", obs, b);
        end
    endtask

    task automatic test_flush();
        instr_t t;
        id = rand_instr();
        tick();
        t = rand_instr();
        t.b = 1'b1; t.wb_en = 1'b1; t.dest = 4'd9; t.pc = 32'h0000_0200;
        id = t;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_tests++;
        if (exe_valid !== 1'b0 || exe_b !== 1'b0 || exe_wb_en !== 1'b0 ||
            exe_dest !== 4'd0 || exe_pc !== 32'd0) begin
            n_fail++; $display("FAIL flush_fields valid=%b b=%b wb=%b dest=%0d pc=%h exp all 0",
                               exe_valid, exe_b, exe_wb_en, exe_dest, exe_pc);
        end
        n_tests++;
        if (obs !== 156'd0) begin
            n_fail++; $display("FAIL flush_all obs=%h exp=0", obs);
        end
    endtask

    task automatic test_freeze_flush();
        instr_t a, b;
        a = rand_instr();
        b = rand_instr();
        id = a;
        tick();
        freeze = 1'b1; flush = 1'b1; id = b;
        tick();
        n_tests++;
        if (obs !== a) begin
            n_fail++; $display("FAIL freeze_beats_flush obs=%h exp=%h", obs, a);
        end
        freeze = 1'b0;
        tick();
        n_tests++;
        if (obs !== 156'd0) begin
            n_fail++; $display("FAIL flush_after_freeze obs=%h exp=0", obs);
        end
        flush = 1'b0;
        tick();
        n_tests++;
        if (obs !== b) begin
            n_fail++; $display("FAIL load_after_flush obs=%h exp=%h", obs, b);
        end
    endtask

    task automatic test_rst_freeze();
        instr_t a;
        a = rand_instr();
        id = a;
        tick();
        freeze = 1'b1;
        tick();
        n_tests++;
        if (obs !== a) begin
            n_fail++; $display("FAIL pre_rst_hold obs=%h exp=%h", obs, a);
        end
        rst = 1'b1;
        tick();
        n_tests++;
        if (obs !== 156'd0) begin
            n_fail++; $display("FAIL rst_in_freeze obs=%h exp=0", obs);
        end
        rst = 1'b0;
        tick();
        n_tests++;
        if (obs !== 156'd0) begin
            n_fail++; $display("FAIL freeze_after_rst obs=%h exp=0", obs);
        end
        freeze = 1'b0;
    endtask

    task automatic test_back_to_back();
        instr_t seq [4];
        for (int i = 0; i < 4; i++) seq[i] = rand_instr();
        seq[2].valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            id = seq[i];
            tick();
            n_tests++;
            if (obs !== (seq[i].valid ? seq[i] : instr_t'(0))) begin
                n_fail++; $display("FAIL b2b_%0d obs=%h exp=%h", i, obs,
                                   seq[i].valid ? seq[i] : instr_t'(0));
            end
        end
    endtask

    initial begin
        rst = 1'b1; freeze = 1'b0; flush = 1'b0; id = '0;
        #1;
        test_reset();
        test_load();
        test_invalid();
        test_freeze();
        test_flush();
        test_freeze_flush();
        test_rst_freeze();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
